mvm_param: RTL

- Parametrised streaming matrix-vector unit, successor to the fixed 3x3 mvm3 blocks.
- Computes y = M*x + b for an N x N signed matrix and length-N vectors, with optional bias.
- Output saturates; optional ReLU clamp.
- Single valid/ready slave input stream and single valid/ready master output stream; one multiply-accumulate per cycle.

---
 rtl/mvm_pkg.sv | 22 ++
 rtl/mvm_param_if.sv | 15 +
 rtl/mvm_mac.sv | 28 ++
 rtl/mvm_param.sv | 109 ++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared types and arithmetic helpers for the parametrised matrix-vector unit.
package mvm_pkg;

   typedef enum logic [1:0] {LOAD, COMP, OUT} state_t;

   // Accumulator width that holds N full-width products plus a bias without overflow
   function automatic int accw(input int iw, input int n);
      return 2*iw + $clog2(n) + 1;
   endfunction

   function automatic logic signed [63:0] post(input logic signed [63:0] v,
                                               input int ow, input bit sat, input bit relu);
      logic signed [63:0] maxV, minV, res;
      maxV = (64'sd1 <<< (ow-1)) - 64'sd1;
      minV = -(64'sd1 <<< (ow-1));
      if (sat) res = (v > maxV) ? maxV : ((v < minV) ? minV : v);
      else     res = (v <<< (64-ow)) >>> (64-ow);
      if (relu && (res < 0)) res = '0;
      return res;
   endfunction

endpackage

// File: rtl/mvm_param_if.sv
// Valid/ready streams of the matrix-vector unit; slave is the block's view, master the environment's.
interface mvm_param_if #(
   parameter int IW = 8,
   parameter int OW = 16
);
   logic                 s_valid;
   logic                 s_ready;
   logic signed [IW-1:0] data_in;
   logic                 m_valid;
   logic                 m_ready;
   logic signed [OW-1:0] data_out;

   modport slave  (input s_valid, m_ready, data_in, output s_ready, m_valid, data_out);
   modport master (output s_valid, m_ready, data_in, input s_ready, m_valid, data_out);
endinterface

// File: rtl/mvm_mac.sv
// Signed multiply-accumulate: loads a bias or adds one product per enabled cycle.
module mvm_mac
   import mvm_pkg::*;
#(
   parameter int IW = 8,
   parameter int AW = 19
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_load,
   input  logic                 i_acc,
   input  logic signed [AW-1:0] i_bias,
   input  logic signed [IW-1:0] i_a,
   input  logic signed [IW-1:0] i_b,
   output logic signed [AW-1:0] o_nextSum
);
   logic signed [AW-1:0]   r_acc;
   logic signed [2*IW-1:0] w_prod;

   assign w_prod    = i_a * i_b;
   assign o_nextSum = r_acc + AW'(w_prod);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      r_acc <= '0;
      else if (i_load) r_acc <= i_bias;
      else if (i_acc)  r_acc <= o_nextSum;
   end
endmodule

// File: rtl/mvm_param.sv
// Streaming y = M*x + b: buffers one frame, then emits N results computed with one MAC per cycle.
module mvm_param
   import mvm_pkg::*;
#(
   parameter int N       = 3,
   parameter int IW      = 8,
   parameter int OW      = 16,
   parameter int BIAS_EN = 1,
   parameter int SAT_EN  = 1,
   parameter int RELU_EN = 0
) (
   input logic        clk,
   input logic        reset,
   mvm_param_if.slave bus
);
   localparam int AW = accw(IW, N);
   localparam int L  = N*N + N*(1 + BIAS_EN);
   localparam int LB = N*N + 2*N;
   localparam int BW = $clog2(LB);
   localparam int RW = $clog2(N);

   state_t               r_state, w_nextState;
   logic signed [IW-1:0] r_buf [LB];
   logic [BW-1:0]        r_cnt, r_mPtr, w_xIdx, w_biasIdx;
   logic [RW-1:0]        r_row, r_col;
   logic [OW-1:0]        r_dataOut;
   logic signed [AW-1:0] w_bias, w_nextSum;
   logic                 w_accept, w_lastWord, w_lastCol, w_lastRow, w_outHs, w_loadAcc;

   assign w_accept   = bus.s_valid && bus.s_ready;
   assign w_lastWord = (r_cnt == BW'(L-1));
   assign w_lastCol  = (r_col == RW'(N-1));
   assign w_lastRow  = (r_row == RW'(N-1));
   assign w_outHs    = bus.m_valid && bus.m_ready;
   assign w_loadAcc  = (w_accept && w_lastWord) || (w_outHs && !w_lastRow);

   // Matrix is walked linearly by r_mPtr; bias slot is row 0 at frame end, else the next row
   assign w_xIdx    = BW'(N*N) + BW'(r_col);
   assign w_biasIdx = (r_state == LOAD) ? BW'(N*N + N) : BW'(N*N + N + 1) + BW'(r_row);
   assign w_bias    = (BIAS_EN != 0) ? AW'(r_buf[w_biasIdx]) : '0;
   assign bus.data_out = r_dataOut;

   mvm_mac #(.IW(IW), .AW(AW)) u_mac (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_loadAcc),
      .i_acc     (r_state == COMP),
      .i_bias    (w_bias),
      .i_a       (r_buf[r_mPtr]),
      .i_b       (r_buf[w_xIdx]),
      .o_nextSum (w_nextSum)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= LOAD;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         LOAD:    if (w_accept && w_lastWord) w_nextState = COMP;
         COMP:    if (w_lastCol) w_nextState = OUT;
         OUT:     if (w_outHs) w_nextState = w_lastRow ? LOAD : COMP;
         default: w_nextState = LOAD;
      endcase
   end

   // s_ready stays low while reset is held even though the state already reads LOAD
   always_comb begin
      bus.s_ready = 1'b0;
      bus.m_valid = 1'b0;
      case (r_state)
         LOAD:    bus.s_ready = reset;
         OUT:     bus.m_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LB; i++) r_buf[i] <= '0;
         r_cnt     <= '0;
         r_mPtr    <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_dataOut <= '0;
      end else begin
         if (w_accept) begin
            r_buf[r_cnt] <= bus.data_in;
            r_cnt        <= w_lastWord ? '0 : r_cnt + BW'(1);
         end
         if (w_accept && w_lastWord) begin
            r_row  <= '0;
            r_col  <= '0;
            r_mPtr <= '0;
         end
         if (r_state == COMP) begin
            r_col  <= r_col + RW'(1);
            r_mPtr <= r_mPtr + BW'(1);
            if (w_lastCol) r_dataOut <= OW'(post(64'(w_nextSum), OW, SAT_EN != 0, RELU_EN != 0));
         end
         if (w_outHs && !w_lastRow) begin
            r_row <= r_row + RW'(1);
            r_col <= '0;
         end
      end
   end
endmodule
